// File: rtl/paper_tape_punch.sv
// rtl/paper_tape_punch.sv - paper-tape punch that double-buffers bytes into 512-byte SD sectors
// Optional flush/padding of a partial final sector: PAPER_TAPE_PUNCH_FLUSH_EN
module paper_tape_punch (
   input  logic        clk,
   input  logic        reset,
   input  logic        img_mounted,
   input  logic        img_readonly,
   input  logic [31:0] img_size,
   input  logic [7:0]  punch_data,
   input  logic        punch_valid,
   output logic        punch_ready,
`ifdef PAPER_TAPE_PUNCH_FLUSH_EN
   input  logic        punch_flush,
`endif
   input  logic        sd_ack,
   input  logic [8:0]  sd_buff_addr,
   output logic [7:0]  sd_buff_din,
   output logic [31:0] sd_lba,
   output logic        sd_wr,
   output logic        sd_rd,
   output logic [31:0] punch_position,
   output logic        tape_full,
   output logic        write_protected,
   output logic        busy
);

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_XFER} wstate_t;
   wstate_t state, state_nxt;

   logic [7:0]  buf_mem [0:1023];
   logic        mounted, mounted_q, ack_q, mount_pending;
   logic        pend_readonly;
   logic [31:0] pend_size, cap;
   logic [8:0]  fill_ptr;
   logic        fill_half, wr_half;
   logic [1:0]  half_full, half_full_nxt;
   logic        padding;
   logic        mount_edge, apply_mount, accept, fill_wr, fill_wrap, xfer_done;
   logic        new_readonly;
   logic [31:0] new_size;
   logic [7:0]  fill_byte;

   // A mount seen mid-transfer is held until the write FSM is idle again
   assign mount_edge   = img_mounted & ~mounted_q;
   assign apply_mount  = (state == W_IDLE) & (mount_edge | mount_pending);
   assign new_size     = mount_edge ? img_size : pend_size;
   assign new_readonly = mount_edge ? img_readonly : pend_readonly;

   assign accept    = punch_valid & punch_ready;
   assign fill_wr   = accept | padding;
   assign fill_byte = padding ? 8'h00 : punch_data;
   assign fill_wrap = fill_wr & (fill_ptr == 9'd511);
   assign xfer_done = (state == W_XFER) & ack_q & ~sd_ack;

   assign tape_full   = mounted & (punch_position == cap);
   assign punch_ready = mounted & ~write_protected & ~tape_full & ~half_full[fill_half]
                        & ~padding & ~mount_pending;
   assign sd_rd       = 1'b0;

   // Fill and drain always target different halves, so set and clear never collide
   always_comb begin
      half_full_nxt = half_full;
      if (fill_wrap) half_full_nxt[fill_half] = 1'b1;
      if (xfer_done) half_full_nxt[wr_half]   = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mounted_q       <= 1'b0;
         ack_q           <= 1'b0;
         mounted         <= 1'b0;
         write_protected <= 1'b0;
         cap             <= 32'd0;
         mount_pending   <= 1'b0;
         pend_readonly   <= 1'b0;
         pend_size       <= 32'd0;
         punch_position  <= 32'd0;
         fill_ptr        <= 9'd0;
         fill_half       <= 1'b0;
         wr_half         <= 1'b0;
         half_full       <= 2'b00;
         sd_lba          <= 32'd0;
      end else begin
         mounted_q <= img_mounted;
         ack_q     <= sd_ack;
         if (mount_edge) begin
            pend_readonly <= img_readonly;
            pend_size     <= img_size;
         end
         if (apply_mount) begin
            mounted         <= |new_size;
            write_protected <= new_readonly;
            cap             <= new_size;
            mount_pending   <= 1'b0;
            punch_position  <= 32'd0;
            fill_ptr        <= 9'd0;
            fill_half       <= 1'b0;
            wr_half         <= 1'b0;
            half_full       <= 2'b00;
            sd_lba          <= 32'd0;
         end else begin
            if (mount_edge) mount_pending <= 1'b1;
            half_full <= half_full_nxt;
            if (fill_wr)   fill_ptr       <= fill_ptr + 9'd1;
            if (accept)    punch_position <= punch_position + 32'd1;
            if (fill_wrap) fill_half      <= ~fill_half;
            if (xfer_done) begin
               wr_half <= ~wr_half;
               sd_lba  <= sd_lba + 32'd1;
            end
         end
      end
   end

`ifdef PAPER_TAPE_PUNCH_FLUSH_EN
   logic [8:0] fill_ptr_nxt;
   logic       pad_start;

   // Judge emptiness on the post-write pointer so a flush racing a wrap is ignored
   assign fill_ptr_nxt = fill_wr ? fill_ptr + 9'd1 : fill_ptr;
   assign pad_start    = (punch_flush | tape_full) & (fill_ptr_nxt != 9'd0);

   always_ff @(posedge clk) begin
      if (reset || apply_mount) padding <= 1'b0;
      else if (padding)         padding <= ~fill_wrap;
      else if (pad_start)       padding <= 1'b1;
   end
`else
   assign padding = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (fill_wr) buf_mem[{fill_half, fill_ptr}] <= fill_byte;
   end

   always_ff @(posedge clk) begin
      if (reset) sd_buff_din <= 8'h00;
      else       sd_buff_din <= buf_mem[{wr_half, sd_buff_addr}];
   end

   always_ff @(posedge clk) begin
      if (reset) state <= W_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         W_IDLE:  if (!apply_mount && half_full[wr_half]) state_nxt = W_REQ;
         W_REQ:   if (sd_ack) state_nxt = W_XFER;
         W_XFER:  if (ack_q && !sd_ack) state_nxt = W_IDLE;
         default: state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      sd_wr = (state == W_REQ);
      busy  = (state != W_IDLE) | (|half_full);
   end

endmodule

// File: doc/paper_tape_punch.md
# paper_tape_punch

Paper-tape punch: accepts bytes from the CPU punch interface and writes them sector-by-sector into a mounted SD image, using the MiSTer `sd_*` block interface. This is the write-direction counterpart of the tape reader and sits between the punch I/O logic and the HPS SD bridge. It double-buffers 512-byte sectors, so punching continues while the previous sector is written out.

## Interface
- No parameters. Sector size is fixed at 512 bytes; the buffer is 2 x 512 x 8.
- One clock; reset is synchronous and active-high.

Ports:
- `clk` in 1: single clock for all logic, including the SD side.
- `reset` in 1: synchronous, active-high.
- `img_mounted` in 1: a rising edge (re)mounts the image.
- `img_readonly` in 1: sampled at the mount edge.
- `img_size` in 32: image size in bytes, sampled at the mount edge; 0 means unmounted.
- `punch_data` in 8: byte to punch.
- `punch_valid` in 1: byte offered.
- `punch_ready` out 1: byte accepted when `punch_valid && punch_ready`.
- `punch_flush` in 1: one-cycle pulse; only exists with `PAPER_TAPE_PUNCH_FLUSH_EN`.
- `sd_ack` in 1: HPS transfer in progress.
- `sd_buff_addr` in 9: HPS read address into the sector being written.
- `sd_buff_din` out 8: data for `sd_buff_addr`.
- `sd_lba` out 32: sector number.
- `sd_wr` out 1: write request.
- `sd_rd` out 1: constant 0.
- `punch_position` out 32: bytes accepted since mount.
- `tape_full` out 1: `punch_position` has reached the capacity.
- `write_protected` out 1: the mounted image is read-only.
- `busy` out 1: write FSM not idle, or a half-buffer is pending.

## Operation
- **Mount edge** (`img_mounted` 0->1, detected on a registered copy):
  - Latch `mounted = |img_size`, `write_protected = img_readonly`, `cap = img_size`.
  - Clear `punch_position`, fill pointer, `fill_half`, both half-full flags, and `sd_lba`.
  - If the write FSM is not in `W_IDLE`, set the edge pending; apply it when the FSM returns to `W_IDLE`.
- **Fill side:**
  - `punch_ready = mounted & ~write_protected & ~tape_full & ~half_full[fill_half] & ~padding & ~mount_pending`.
  - Accepted byte is written to `buf[{fill_half, fill_ptr}]`; `fill_ptr++` and `punch_position++`.
  - When `fill_ptr` wraps 511->0: set `half_full[fill_half]`, then toggle `fill_half`.
  - `tape_full = (punch_position == cap)`. A partial final sector is written only via flush (see Configuration).
- **Write FSM** (`W_IDLE`, `W_REQ`, `W_XFER`):
  - `W_IDLE`: if `half_full[wr_half]`, assert `sd_wr`, go to `W_REQ`.
  - `W_REQ`: hold `sd_wr=1` until `sd_ack=1`, then deassert `sd_wr` and go to `W_XFER`.
  - `W_XFER`: on `sd_ack` 1->0:
    - clear `half_full[wr_half]`;
    - toggle `wr_half`;
    - `sd_lba <= sd_lba + 1` (32-bit, wraps silently);
    - go to `W_IDLE`.
  - `sd_buff_din = buf[{wr_half, sd_buff_addr}]`, registered.
  - `sd_lba` is stable from `sd_wr` assertion through `W_XFER`.
- **Simultaneous events:** a half-full set and a clear on different halves in the same cycle are both applied.
- **Reset:** returns everything to the reset values below, regardless of FSM state. The buffer contents are don't-care.

## Timing
- Reset values:
  - `punch_ready` 0, `sd_wr` 0, `sd_rd` 0, `sd_lba` 0;
  - `punch_position` 0, `tape_full` 0, `write_protected` 0, `busy` 0;
  - `sd_buff_din` 0; state unmounted, `W_IDLE`.
- `punch_ready` drops in the cycle after the accept that fills a half, but only if the other half is still full.
- `sd_wr` rises 1 cycle after a half becomes full, if the FSM is in `W_IDLE`.
- `sd_buff_din` is valid 1 clk after `sd_buff_addr` changes.
- The next sector request is issued ≥1 clk after `sd_ack` falls.
- A mount edge takes effect 1 clk after detection, or 1 clk after `W_IDLE` is re-entered if deferred.

## Configuration
- `PAPER_TAPE_PUNCH_FLUSH_EN` defined:
  - `punch_flush` port exists.
  - A pulse with `fill_ptr != 0` enters a padding state: `punch_ready=0`, and one zero byte per clk is written until `fill_ptr` wraps. The half is then queued normally.
  - `punch_position` is not advanced by pad bytes.
  - A flush with `fill_ptr == 0` is ignored.
  - Reaching `tape_full` with `fill_ptr != 0` triggers the same padding automatically.
- Not defined: no port, no padding state; a trailing partial sector is never written.

## Test plan
- Mount 2048-byte RW image, punch 512 bytes 0x00..0xFF repeating -> one `sd_wr` with `sd_lba`=0; the HPS model reads addr 0..511 and gets the same pattern 1 clk delayed; then `sd_lba`=1.
- Punch 1024 bytes back-to-back while the model holds `sd_ack` for 600 clk -> `punch_ready` low only after byte 1024 while half 0 is still busy; two writes at LBA 0 and 1, no data loss.
- Mount with `img_readonly`=1 -> `write_protected`=1, `punch_ready` stays 0, no `sd_wr`.
- Mount 600-byte image, punch 600 bytes -> `tape_full`=1 at position 600. With FLUSH_EN: LBA 1 is written with 88 data bytes + 424 zeros. Without: only LBA 0 is written.
- Remount pulse during `W_XFER` -> current transfer completes; then `sd_lba`=0 and `punch_position`=0, with `punch_ready` low until then.
- Reset asserted in `W_REQ` -> `sd_wr`=0, all outputs at reset values the next clk.
